// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS-485 UART transmit/receive path.
// Frame states, parity modes and clock-rate helper.
package rs485_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_TAIL
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int CLK_HZ = 100_000_000;

  // Rounded to the nearest whole cycle.
  function automatic int baud_to_clks(input int baud);
    return (CLK_HZ + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/rs485_sync_fifo.sv
// Registered first-word-fall-through FIFO with full/empty flags.
// The head entry sits in an output register; count covers it too.
module rs485_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             out_valid;
  logic             do_wr;
  logic             do_rd;
  logic             do_load;

  assign count   = mem_cnt + CW'(out_valid);
  assign full    = count == CW'(DEPTH);
  assign empty   = !out_valid;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && out_valid;
  assign do_load = (mem_cnt != '0) && (!out_valid || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_load) begin
        rd_data   <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (do_rd) begin
        out_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CW'(do_wr) - CW'(do_load);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rs485_uart_tx_fifo.sv
// RS-485 UART transmitter with input FIFO, baud divider and
// driver-enable guard times around each burst of frames.
module rs485_uart_tx_fifo
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DE_LEAD      = 1,
  parameter int DE_TAIL      = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 uart_tx,
  output logic                 de,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (DE_LEAD < 0 || DE_TAIL < 0) begin : g_bad_guard
    $error("DE_LEAD and DE_TAIL must be >= 0");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int GMAX = (DE_LEAD > DE_TAIL) ? DE_LEAD : DE_TAIL;
  localparam int GW   = (GMAX < 1) ? 1 : $clog2(GMAX + 1);
  localparam int FW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [GW-1:0] LEAD_LAST = GW'(DE_LEAD - 1);
  localparam logic [GW-1:0] TAIL_LAST = GW'(DE_TAIL - 1);

  tx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [GW-1:0]        gcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FW-1:0]        fifo_count;

  logic bit_end;
  logic stop_last;
  logic tail_last;
  logic pop;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  rs485_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign bit_end   = cnt == CNT_LAST;
  assign stop_last = (state == S_STOP) && (bit_cnt == STOP_LAST);
  assign tail_last = (state == S_TAIL) && (gcnt == TAIL_LAST);
  // Next byte chains straight onto a finished frame while de is up.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) ||
                (bit_end && (stop_last || tail_last)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      gcnt    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      uart_tx <= 1'b1;
      de      <= 1'b0;
      tx_done <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      tx_done <= stop_last && (cnt == CNT_PRE);
      tx_busy <= (state != S_IDLE) || (fifo_count != '0);
      cnt     <= (state == S_IDLE || bit_end) ? '0 : cnt + 1'b1;
      if (pop) begin
        shreg   <= fifo_data;
        par_bit <= par_of(fifo_data);
        bit_cnt <= '0;
        gcnt    <= '0;
        de      <= 1'b1;
        if (state == S_IDLE && DE_LEAD > 0) begin
          state   <= S_LEAD;
          uart_tx <= 1'b1;
        end else begin
          state   <= S_START;
          uart_tx <= 1'b0;
        end
      end else if (bit_end) begin
        unique case (state)
          S_IDLE: ;
          S_LEAD: begin
            if (gcnt == LEAD_LAST) begin
              state   <= S_START;
              uart_tx <= 1'b0;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          S_START: begin
            state   <= S_DATA;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
          end
          S_DATA: begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state   <= S_PAR;
                uart_tx <= par_bit;
              end else begin
                state   <= S_STOP;
                uart_tx <= 1'b1;
              end
            end else begin
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_PAR: begin
            state   <= S_STOP;
            uart_tx <= 1'b1;
          end
          S_STOP: begin
            if (bit_cnt == STOP_LAST) begin
              if (DE_TAIL > 0) begin
                state <= S_TAIL;
                gcnt  <= '0;
              end else begin
                state <= S_IDLE;
                de    <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_TAIL: begin
            if (gcnt == TAIL_LAST) begin
              state <= S_IDLE;
              de    <= 1'b0;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            uart_tx <= 1'b1;
            de      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
